// File: rtl/hd_pkg.sv
// Shared definitions for the handshake transmitter: FSM states and default widths.
package hd_pkg;

    localparam int HD_DATA_WIDTH = 16;
    localparam int HD_LEN_WIDTH  = 16;
    localparam int HD_GAP_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } hd_state_e;

endpackage

// File: rtl/hd_gap_timer.sv
// Idle-gap down-counter: loaded with N on a handshake, flags expiry in the last of N cycles.
module hd_gap_timer
    import hd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [HD_GAP_WIDTH-1:0] i_n,
    output logic                    o_expire
);

    logic [HD_GAP_WIDTH-1:0] r_cnt;

    // Load on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {HD_GAP_WIDTH{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_n;
        end else if (r_cnt != {HD_GAP_WIDTH{1'b0}}) begin
            r_cnt <= r_cnt - {{(HD_GAP_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // A count of one means this is the final idle cycle.
    assign o_expire = (r_cnt == {{(HD_GAP_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hd_tx.sv
// Ready/valid burst transmitter: emits len beats starting at base, stepping by STEP,
// with an optional idle gap after each accepted beat.
module hd_tx
    import hd_pkg::*;
#(
    parameter int DATA_WIDTH = HD_DATA_WIDTH,
    parameter int LEN_WIDTH  = HD_LEN_WIDTH,
    parameter int STEP       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [DATA_WIDTH-1:0]   base,
    input  logic [HD_GAP_WIDTH-1:0] gap,
    input  logic                    ready,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   data_src,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    sent_cnt
);

    localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);
    localparam logic [LEN_WIDTH-1:0]  ONE_L  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    hd_state_e              r_state;
    hd_state_e              w_next_state;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic                   w_hs;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_zero_start;
    logic                   w_done_nxt;
    logic                   w_gap_load;
    logic                   w_gap_expire;

    assign w_hs         = r_valid & ready;
    assign w_last       = (r_cnt == (r_len - ONE_L));
    assign w_accept     = (r_state == IDLE) & start & (len != {LEN_WIDTH{1'b0}});
    assign w_zero_start = (r_state == IDLE) & start & (len == {LEN_WIDTH{1'b0}});

    hd_gap_timer u_gap_timer (
        .clk      (clk),
        .rst_n    (rst),
        .i_load   (w_gap_load),
        .i_n      (gap),
        .o_expire (w_gap_expire)
    );

    // Next-state decode; gap is only consulted on a non-final handshake.
    always_comb begin
        w_next_state = r_state;
        w_done_nxt   = 1'b0;
        w_gap_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SEND;
                end else if (w_zero_start) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SEND: begin
                if (w_hs && w_last) begin
                    w_next_state = IDLE;
                    w_done_nxt   = 1'b1;
                end else if (w_hs && (gap != {HD_GAP_WIDTH{1'b0}})) begin
                    w_next_state = GAP;
                    w_gap_load   = 1'b1;
                end else begin
                    w_next_state = SEND;
                end
            end
            GAP: begin
                if (w_gap_expire) begin
                    w_next_state = SEND;
                end else begin
                    w_next_state = GAP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State and status flags, registered from the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= (w_next_state == SEND);
            r_busy  <= (w_next_state != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Burst parameters, payload and beat counter; counter holds after the burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= {DATA_WIDTH{1'b0}};
            r_len  <= {LEN_WIDTH{1'b0}};
            r_cnt  <= {LEN_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_data <= base;
            r_len  <= len;
            r_cnt  <= {LEN_WIDTH{1'b0}};
        end else if (w_zero_start) begin
            r_cnt  <= {LEN_WIDTH{1'b0}};
        end else if (w_hs) begin
            r_data <= r_data + STEP_V;
            r_cnt  <= r_cnt + ONE_L;
        end else begin
            r_data <= r_data;
            r_cnt  <= r_cnt;
        end
    end

    assign valid    = r_valid;
    assign data_src = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sent_cnt = r_cnt;

endmodule

// File: tb/tb_hd_tx.sv
// Directed self-checking bench for hd_tx: default instance plus a narrow instance
// with STEP=3 to exercise the maximum-length burst.
module tb_hd_tx;

    logic        clk;
    logic        rst;

    logic        start;
    logic [15:0] len;
    logic [15:0] base;
    logic [3:0]  gap;
    logic        ready;
    logic        valid;
    logic [15:0] data_src;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;

    logic        b_start;
    logic [3:0]  b_len;
    logic [7:0]  b_base;
    logic [3:0]  b_gap;
    logic        b_ready;
    logic        b_valid;
    logic [7:0]  b_data;
    logic        b_busy;
    logic        b_done;
    logic [3:0]  b_cnt;

    int n_checks;
    int n_fail;

    hd_tx u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .base     (base),
        .gap      (gap),
        .ready    (ready),
        .valid    (valid),
        .data_src (data_src),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    hd_tx #(.DATA_WIDTH(8), .LEN_WIDTH(4), .STEP(3)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .len      (b_len),
        .base     (b_base),
        .gap      (b_gap),
        .ready    (b_ready),
        .valid    (b_valid),
        .data_src (b_data),
        .busy     (b_busy),
        .done     (b_done),
        .sent_cnt (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp3 [3];
    logic [6:0]  gap_pat;
    logic [7:0]  b_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        start = 1'b0; len = 16'd0; base = 16'd0; gap = 4'd0; ready = 1'b0;
        b_start = 1'b0; b_len = 4'd0; b_base = 8'd0; b_gap = 4'd0; b_ready = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_data", 32'(data_src), 32'd0);
        check_eq("rst_cnt", 32'(sent_cnt), 32'd0);
        rst = 1'b1;
        step();

        // Back-to-back burst of four beats
        base = 16'd1; len = 16'd4; gap = 4'd0; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("s1_done_early", 32'(done), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check_eq("s1_valid", 32'(valid), 32'd1);
            check_eq("s1_busy", 32'(busy), 32'd1);
            check_eq("s1_data", 32'(data_src), 32'(i));
            step();
        end
        check_eq("s1_valid_end", 32'(valid), 32'd0);
        check_eq("s1_done", 32'(done), 32'd1);
        check_eq("s1_busy_end", 32'(busy), 32'd0);
        check_eq("s1_cnt", 32'(sent_cnt), 32'd4);
        step();
        check_eq("s1_done_once", 32'(done), 32'd0);
        check_eq("s1_cnt_hold", 32'(sent_cnt), 32'd4);

        // Backpressure: ready low for three cycles
        base = 16'd1; len = 16'd3; ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("s2_hold_valid", 32'(valid), 32'd1);
            check_eq("s2_hold_data", 32'(data_src), 32'd1);
            step();
        end
        ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check_eq("s2_valid", 32'(valid), 32'd1);
            check_eq("s2_data", 32'(data_src), 32'(i));
            step();
        end
        check_eq("s2_done", 32'(done), 32'd1);
        check_eq("s2_cnt", 32'(sent_cnt), 32'd3);
        step();

        // Payload wraps modulo 2^16
        exp3[0] = 16'hFFFE; exp3[1] = 16'hFFFF; exp3[2] = 16'h0000;
        base = 16'hFFFE; len = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("s3_data", 32'(data_src), 32'(exp3[i]));
            step();
        end
        check_eq("s3_done", 32'(done), 32'd1);
        step();

        // Two idle cycles after each non-final beat
        gap_pat = 7'b1001001;
        base = 16'h0010; len = 16'd3; gap = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_eq("s4_valid", 32'(valid), 32'(gap_pat[6-i]));
            check_eq("s4_busy", 32'(busy), 32'd1);
            step();
        end
        check_eq("s4_done", 32'(done), 32'd1);
        check_eq("s4_valid_end", 32'(valid), 32'd0);
        check_eq("s4_cnt", 32'(sent_cnt), 32'd3);
        gap = 4'd0;
        step();

        // Zero-length burst
        len = 16'd0; base = 16'h0055; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("s5_zero_done", 32'(done), 32'd1);
        check_eq("s5_zero_valid", 32'(valid), 32'd0);
        check_eq("s5_zero_busy", 32'(busy), 32'd0);
        check_eq("s5_zero_cnt", 32'(sent_cnt), 32'd0);
        step();
        check_eq("s5_zero_done2", 32'(done), 32'd0);
        check_eq("s5_zero_valid2", 32'(valid), 32'd0);

        // Start during a burst is ignored
        len = 16'd2; base = 16'h0020; ready = 1'b0; start = 1'b1;
        step();
        len = 16'd5; base = 16'h0099;
        step();
        start = 1'b0;
        check_eq("s5_ign_data", 32'(data_src), 32'h20);
        check_eq("s5_ign_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_eq("s5_data", 32'(data_src), 32'(16'h0020 + i));
            step();
        end
        check_eq("s5_done", 32'(done), 32'd1);
        check_eq("s5_cnt", 32'(sent_cnt), 32'd2);

        // Start accepted in the done cycle
        len = 16'd1; base = 16'h0007; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("s5_rest_valid", 32'(valid), 32'd1);
        check_eq("s5_rest_data", 32'(data_src), 32'h7);
        check_eq("s5_rest_cnt", 32'(sent_cnt), 32'd0);
        step();
        check_eq("s5_rest_done", 32'(done), 32'd1);
        check_eq("s5_rest_cnt1", 32'(sent_cnt), 32'd1);
        step();

        // Asynchronous reset after two of five beats
        base = 16'h0040; len = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("s6_data0", 32'(data_src), 32'h40);
        step();
        check_eq("s6_data1", 32'(data_src), 32'h41);
        step();
        check_eq("s6_cnt2", 32'(sent_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("s6_async_valid", 32'(valid), 32'd0);
        check_eq("s6_async_busy", 32'(busy), 32'd0);
        check_eq("s6_async_data", 32'(data_src), 32'd0);
        check_eq("s6_async_cnt", 32'(sent_cnt), 32'd0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("s6_no_resume", 32'(valid), 32'd0);
            check_eq("s6_idle_busy", 32'(busy), 32'd0);
        end
        ready = 1'b0;

        // Maximum length on the narrow instance, STEP=3 with wrap
        b_base = 8'hF0; b_len = 4'hF; b_gap = 4'd0; b_ready = 1'b1; b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_exp = 8'hF0;
        for (int i = 0; i < 15; i++) begin
            check_eq("b_valid", 32'(b_valid), 32'd1);
            check_eq("b_data", 32'(b_data), 32'(b_exp));
            b_exp = b_exp + 8'd3;
            step();
        end
        check_eq("b_done", 32'(b_done), 32'd1);
        check_eq("b_cnt", 32'(b_cnt), 32'hF);
        check_eq("b_busy", 32'(b_busy), 32'd0);
        check_eq("b_last_data", 32'(b_data), 32'h1D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hd_tx.md
HD_TX -- requirements
Module: hd_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of data_src and base.
REQ-002 Parameter LEN_WIDTH, default 16: width of len and sent_cnt.
REQ-003 Parameter STEP, default 1: increment added to data_src between consecutive beats.
REQ-004 Port list (name, direction, width, meaning):
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin a burst.
- len, input, LEN_WIDTH: number of beats in the burst.
- base, input, DATA_WIDTH: data value of the first beat.
- gap, input, 4: idle cycles inserted after each accepted beat.
- ready, input, 1: sink can accept data.
- valid, output, 1: data_src holds a beat.
- data_src, output, DATA_WIDTH: beat payload.
- busy, output, 1: burst in progress.
- done, output, 1: one-cycle pulse when a burst completes.
- sent_cnt, output, LEN_WIDTH: beats accepted in the current or last burst.

Function
REQ-005 hd_tx SHALL be the transmitter end of the ready/valid handshake: a beat transfers on a rising clk edge where valid and ready are both 1.
REQ-006 hd_tx SHALL implement FSM states IDLE, SEND and GAP.
REQ-007 In IDLE, start=1 with len!=0 SHALL capture len and base, clear sent_cnt, and enter SEND; valid=1 and data_src=base SHALL be presented from the next cycle.
REQ-008 In IDLE, start=1 with len=0 SHALL pulse done on the next cycle, leave sent_cnt=0, and never assert valid.
REQ-009 start SHALL be ignored while busy=1, and len, base and gap changes SHALL not affect a burst in progress, except that gap is sampled at each handshake.
REQ-010 While valid=1 and ready=0, valid and data_src SHALL hold stable; valid SHALL never deassert without a handshake.
REQ-011 On each handshake, sent_cnt SHALL increment by 1 and data_src SHALL advance by STEP, modulo 2^DATA_WIDTH, with no saturation.
REQ-012 On a handshake that is not the last beat: with gap=0, valid SHALL stay 1 with the next data (back-to-back throughput); with gap=N>0, valid SHALL be 0 for exactly N cycles (GAP state), then return to 1 in SEND.
REQ-013 On the last-beat handshake (sent_cnt reaches len), valid SHALL drop the next cycle, done SHALL pulse for 1 cycle, busy SHALL fall, and the FSM SHALL return to IDLE without entering GAP.
REQ-014 busy SHALL be 1 in SEND and GAP, and 0 in IDLE, including the done cycle.
REQ-015 A start arriving in the done cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-016 sent_cnt SHALL hold its final value in IDLE until the next accepted start.
REQ-017 ready asserted while valid=0 SHALL have no effect.
REQ-018 len=2^LEN_WIDTH-1 SHALL complete without counter overflow.

Reset
REQ-019 rst=0 SHALL immediately (asynchronously) force IDLE, valid=0, data_src=0, busy=0, done=0 and sent_cnt=0, including mid-burst.
REQ-020 After rst returns to 1, hd_tx SHALL remain idle until a new start, and the aborted burst SHALL NOT resume.

Structure
REQ-021 Package hd_pkg SHALL hold the FSM state enumeration (IDLE, SEND, GAP) and the default DATA_WIDTH/LEN_WIDTH constants, shared with HD.
REQ-022 The gap down-counter SHALL be a sub-module hd_gap_timer (load N, count to 0, expire flag); all other logic SHALL be in hd_tx.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- base=1, len=4, gap=0, ready=1 constantly -> data_src 1,2,3,4 on four consecutive cycles; done pulses once; sent_cnt=4.
- base=1, len=3, gap=0, ready low for 3 cycles while valid=1 -> data_src holds 1 and valid stays 1 throughout; all three beats delivered in order.
- base=16'hFFFE, len=3, STEP=1 -> beats FFFE, FFFF, 0000.
- len=3, gap=2, ready=1 -> valid pattern 1,0,0,1,0,0,1, then done.
- len=0 -> done pulses one cycle after start; valid never 1; start during an active burst ignored.
- rst=0 asserted mid-burst after 2 of 5 beats -> valid=0 without waiting for a clock edge; no beats follow until a new start.
